bram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of a byte-enabled dual-port BRAM between NUM_REQ requesters (e.g. fetch, load/store and debug masters on one port).
- Per-requester valid/ready request handshake; fixed one-cycle read response routed back to the issuing requester.
- Fully pipelined: one request per cycle.
- Sits directly between the requesters and the BRAM port. The optional clear sequencer zeroes the memory after reset.

---
 rtl/bram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Round-robin arbiter sharing one port of a byte-enabled BRAM between
//   NUM_REQ requesters. One request is accepted per cycle. A read is answered
//   exactly one cycle later on the one-hot resp_valid bit of the requester that
//   issued it. Writes produce no response.
//
//   Optional feature, enabled by defining BRAM_ARB_CLEAR_EN:
//     after reset release the memory is zeroed, one word per cycle, before
//     arbitration starts. With the macro undefined the arbiter starts
//     directly in arbitration.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or 0)
//   req_write             1 = write, 0 = read
//   req_byteEnable/req_address/req_writeData
//                         requester i's field at [i*W +: W]
//   resp_valid            one-hot read response valid
//   resp_readData         shared read data (pass-through of mem_readData)
//   init_done             arbiter is accepting requests
//   mem_*                 BRAM port (readData is registered by the BRAM)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | zeroing memory, address = clear counter (feature only)
// ST_ARB   | round-robin arbitration of requester traffic

module bram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*NUM_BYTES-1:0]  req_byteEnable,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writeData,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_readData,
  output logic                          init_done,
  output logic                          mem_readEnable,
  output logic                          mem_writeEnable,
  output logic [NUM_BYTES-1:0]          mem_writeByteEnable,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_writeData,
  input  logic [DATA_WIDTH-1:0]         mem_readData
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] RR_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               init_done_q;
  logic               arb_active;
  logic               any_valid;
  logic               found_hi;
  logic [IDX_W-1:0]   win_hi, win_lo, winner;

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (&clr_cnt_q) state_d = ST_ARB;
    end
  end

  assign arb_active = reset && (state_q == ST_ARB);
`else
  assign arb_active = reset;
`endif

  assign any_valid = |req_valid;

  // Requesters above rr_ptr take precedence over those at or below it; the
  // lowest index within each group wins, giving the rotating scan order.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(rr_ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = IDX_W'(i);
        end else begin
          win_lo = IDX_W'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Output / issue logic
  always_comb begin
    req_ready           = '0;
    resp_valid_d        = '0;
    mem_readEnable      = 1'b0;
    mem_writeEnable     = 1'b0;
    mem_writeByteEnable = '0;
    mem_address         = '0;
    mem_writeData       = '0;
`ifdef BRAM_ARB_CLEAR_EN
    if (reset && state_q == ST_CLEAR) begin
      mem_writeEnable     = 1'b1;
      mem_writeByteEnable = '1;
      mem_address         = clr_cnt_q;
    end
`endif
    if (arb_active && any_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner == IDX_W'(i)) begin
          req_ready[i]        = 1'b1;
          resp_valid_d[i]     = ~req_write[i];
          mem_writeEnable     = req_write[i];
          mem_readEnable      = ~req_write[i];
          mem_writeByteEnable = req_byteEnable[i*NUM_BYTES +: NUM_BYTES];
          mem_address         = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          mem_writeData       = req_writeData[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign rr_ptr_d = (arb_active && any_valid) ? winner : rr_ptr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= RR_RST;
      resp_valid_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      init_done_q  <= arb_active;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_readData = mem_readData;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: BRAM model, directed stimulus and a
// response scoreboard drained by an independent monitor.

module tb_bram_port_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NB = DW / 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, req_write, resp_valid;
  logic [NR*NB-1:0]  req_byteEnable;
  logic [NR*AW-1:0]  req_address;
  logic [NR*DW-1:0]  req_writeData;
  logic [DW-1:0]     resp_readData, mem_writeData, mem_readData;
  logic              init_done, mem_readEnable, mem_writeEnable;
  logic [NB-1:0]     mem_writeByteEnable;
  logic [AW-1:0]     mem_address;

  bram_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byteEnable(req_byteEnable), .req_address(req_address),
    .req_writeData(req_writeData),
    .resp_valid(resp_valid), .resp_readData(resp_readData),
    .init_done(init_done),
    .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
    .mem_writeByteEnable(mem_writeByteEnable), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  always #5 clock = ~clock;

  // BRAM model with a backdoor write port for preloading
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_writeEnable)
      for (int b = 0; b < NB; b++)
        if (mem_writeByteEnable[b]) mem[mem_address][b*8 +: 8] <= mem_writeData[b*8 +: 8];
    if (mem_readEnable) mem_readData <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [NR-1:0] who;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset) begin
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=%b expected no response", resp_valid);
        end else begin
          mon_e = sb.pop_front();
          check("resp_cycle", 64'(cyc), 64'(mon_e.due));
          check("resp_valid", 64'(resp_valid), 64'(mon_e.who));
          check("resp_data", 64'(resp_readData), 64'(mon_e.data));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_resp: got resp_valid=0 expected %b at cycle %0d", mon_e.who, mon_e.due);
      end
    end
  end

  task automatic idle();
    req_valid      = '0;
    req_write      = '0;
    req_byteEnable = '0;
    req_address    = '0;
    req_writeData  = '0;
  endtask

  task automatic set_req(input int r, input bit wr, input logic [NB-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]              = 1'b1;
    req_write[r]              = wr;
    req_byteEnable[r*NB +: NB] = be;
    req_address[r*AW +: AW]    = a;
    req_writeData[r*DW +: DW]  = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clock);
    bd_we   = 1'b0;
  endtask

  // One request from a single requester; it is accepted at the next posedge.
  task automatic single(input int r, input bit wr, input logic [NB-1:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd);
    @(negedge clock);
    idle();
    set_req(r, wr, be, a, d);
    #1;
    check("grant", 64'(req_ready), 64'(1 << r));
    check("mem_address", 64'(mem_address), 64'(a));
    check("mem_writeEnable", 64'(mem_writeEnable), 64'(wr));
    check("mem_readEnable", 64'(mem_readEnable), 64'(!wr));
    if (wr) begin
      check("mem_byteEnable", 64'(mem_writeByteEnable), 64'(be));
      check("mem_writeData", 64'(mem_writeData), 64'(d));
    end else begin
      sb.push_back('{due: cyc + 1, who: NR'(1 << r), data: exp_rd});
    end
  endtask

  task automatic wait_init(output int edges);
    edges = 0;
    while (!init_done && edges < (1 << AW) + 10) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check("init_done_rise", 64'(init_done), 64'(1));
  endtask

  task automatic drain();
    @(negedge clock);
    idle();
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int clr_cnt;
    bit done;

    idle();
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    reset   = 1'b0;

`ifdef BRAM_ARB_CLEAR_EN
    for (int a = 0; a < 16; a++) preload(AW'(a), 32'hFFFF_0000 | 32'(a + 1));
    preload(AW'((1 << AW) - 1), 32'h1234_5678);
`endif

    // Reset state with both requesters asking
    @(negedge clock);
    set_req(0, 1'b0, '0, 8'h03, '0);
    set_req(1, 1'b0, '0, 8'h04, '0);
    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_mem_readEnable", 64'(mem_readEnable), 64'(0));
    check("rst_mem_writeEnable", 64'(mem_writeEnable), 64'(0));

`ifdef BRAM_ARB_CLEAR_EN
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("init_done_at_release", 64'(init_done), 64'(0));
    clr_cnt = 0;
    done    = 1'b0;
    while (!done && clr_cnt < (1 << AW) + 8) begin
      if (mem_writeEnable && !init_done) begin
        check("clear_req_ready", 64'(req_ready), 64'(0));
        check("clear_address", 64'(mem_address), 64'(clr_cnt));
        check("clear_byteEnable", 64'(mem_writeByteEnable), 64'({NB{1'b1}}));
        check("clear_data", 64'(mem_writeData), 64'(0));
        clr_cnt++;
        @(negedge clock);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    idle();
    check("clear_count", 64'(clr_cnt), 64'(1 << AW));
    wait_init(edges);
    check("init_done_latency", 64'(edges), 64'(1));
    for (int a = 0; a < 16; a++) single(0, 1'b0, '0, AW'(a), '0, 32'h0);
    single(0, 1'b0, '0, AW'((1 << AW) - 1), '0, 32'h0);
    drain();
`else
    @(negedge clock);
    idle();
    reset = 1'b1;
    #1;
    check("init_done_at_release", 64'(init_done), 64'(0));
    wait_init(edges);
    check("init_done_latency", 64'(edges), 64'(1));
`endif

    preload(8'h05, 32'hA5A5_A5A5);
    preload(8'h20, 32'hCCCC_0000);
    preload(8'h00, 32'd10);
    preload(8'h01, 32'd11);
    preload(8'h02, 32'd12);

    // Idle: nothing granted, BRAM port quiet
    @(negedge clock);
    idle();
    #1;
    check("idle_req_ready", 64'(req_ready), 64'(0));
    check("idle_mem_readEnable", 64'(mem_readEnable), 64'(0));
    check("idle_mem_writeEnable", 64'(mem_writeEnable), 64'(0));
    check("idle_mem_address", 64'(mem_address), 64'(0));

    // Single read
    single(0, 1'b0, '0, 8'h05, '0, 32'hA5A5_A5A5);

    // Byte write then readback
    single(1, 1'b1, 4'b0011, 8'h20, 32'hDDDD_EEEE, '0);
    single(1, 1'b0, '0, 8'h20, '0, 32'hCCCC_EEEE);

    // Back-to-back reads
    single(0, 1'b0, '0, 8'h00, '0, 32'd10);
    single(0, 1'b0, '0, 8'h01, '0, 32'd11);
    single(0, 1'b0, '0, 8'h02, '0, 32'd12);
    drain();

    // Reset dropped while a read is accepted
    @(negedge clock);
    idle();
    set_req(0, 1'b0, '0, 8'h05, '0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_req_ready", 64'(req_ready), 64'(0));
    check("midrst_init_done", 64'(init_done), 64'(0));
    @(negedge clock);
    idle();
    @(negedge clock);
    reset = 1'b1;
    wait_init(edges);

    // Contention after reset: strict alternation starting at requester 0
    preload(8'h40, 32'h0000_4040);
    preload(8'h41, 32'h4141_0041);
    @(negedge clock);
    idle();
    set_req(0, 1'b0, '0, 8'h40, '0);
    set_req(1, 1'b0, '0, 8'h41, '0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      check("contention_grant", 64'(req_ready), 64'(1 << (k % 2)));
      sb.push_back('{due: cyc + 1, who: NR'(1 << (k % 2)),
                     data: (k % 2 == 0) ? 32'h0000_4040 : 32'h4141_0041});
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
